// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter_bank
// Description : Per-channel event counters plus a RUN-cycle counter, with
//               halt freeze, cycle watchdog and a registered readout port.
//               Define PERF_SATURATE_EN to make counters saturate instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counter_bank #(
    parameter int              NUM_EVENTS  = 8,
    parameter int              CNT_WIDTH   = 32,
    parameter longint unsigned CYCLE_LIMIT = 100000,
    parameter int              SEL_W       = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  halt,
    input  logic [NUM_EVENTS-1:0] event_vec,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic                  running,
    output logic                  halted,
    output logic                  timeout,
    output logic [NUM_EVENTS-1:0] ovf_vec
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_HALTED  = 2'd2;
    localparam logic [1:0] S_TIMEOUT = 2'd3;

    localparam logic [CNT_WIDTH-1:0] c_ONE     = CNT_WIDTH'(1);
    localparam logic [SEL_W-1:0]     c_CYC_SEL = SEL_W'(NUM_EVENTS);

    logic [1:0]            r_state;
    logic [1:0]            w_stateNext;
    logic [CNT_WIDTH-1:0]  r_cnt [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]  r_cycle;
    logic [CNT_WIDTH-1:0]  w_cycNext;
    logic [CNT_WIDTH-1:0]  r_rdData;
    logic [CNT_WIDTH-1:0]  w_rdNext;
    logic [NUM_EVENTS-1:0] r_ovf;
    logic                  w_counting;
    logic                  w_wdTrip;

    function automatic logic [CNT_WIDTH-1:0] f_bump(input logic [CNT_WIDTH-1:0] v);
`ifdef PERF_SATURATE_EN
        return (&v) ? v : v + c_ONE;
`else
        return v + c_ONE;
`endif
    endfunction

    assign w_counting = (r_state == S_RUN);
    assign w_cycNext  = f_bump(r_cycle);
    assign w_wdTrip   = (CYCLE_LIMIT != 0) && (64'(w_cycNext) == CYCLE_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Priority: clear > halt > watchdog > enable
    always_comb begin
        w_stateNext = r_state;
        if (clear) begin
            w_stateNext = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (enable) w_stateNext = S_RUN;
                S_RUN: begin
                    if (halt)          w_stateNext = S_HALTED;
                    else if (w_wdTrip) w_stateNext = S_TIMEOUT;
                    else if (!enable)  w_stateNext = S_IDLE;
                end
                default: w_stateNext = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cycle <= '0;
            r_ovf   <= '0;
            for (int i = 0; i < NUM_EVENTS; i++) r_cnt[i] <= '0;
        end else if (w_counting) begin
            r_cycle <= w_cycNext;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (event_vec[i]) begin
                    r_cnt[i] <= f_bump(r_cnt[i]);
                    if (&r_cnt[i]) r_ovf[i] <= 1'b1;
                end
            end
        end
    end

    // Out-of-range selects read as zero
    always_comb begin
        w_rdNext = '0;
        if (rd_sel == c_CYC_SEL) w_rdNext = r_cycle;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (rd_sel == SEL_W'(i)) w_rdNext = r_cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= w_rdNext;
        end
    end

    assign rd_data     = r_rdData;
    assign cycle_count = r_cycle;
    assign ovf_vec     = r_ovf;
    assign running     = (r_state == S_RUN);
    assign halted      = (r_state == S_HALTED);
    assign timeout     = (r_state == S_TIMEOUT);

endmodule
`default_nettype wire
